row_policy_cmd_scheduler: RTL and testbench
===========================================

Name: row_policy_cmd_scheduler

Overview:
- Shares the single-rank backend command channel between NUM_REQ frontend requesters, using round-robin arbitration into an in-order command queue.
- Decides the per-command auto-precharge bit. When a second command is queued, it compares row addresses. Otherwise it uses a 2-bit saturating row-hit predictor.
- Routes in-order read data back to the originating requester through a tag FIFO.
- Sits between the frontend requesters and the backend controller.

Parameters:
NUM_REQ, 2, number of frontend requesters (power of two, >=2)
DEPTH, 4, command queue and read-tag FIFO depth (power of two)
ROW_BITS, 14, row address width
COL_BITS, 10, column address width
DATA_BITS, 64, burst data width (DQ_BITS*8)

Ports:
clk  in  1  system clock
power_on_rst  in  1  asynchronous, active-high reset
i_req_valid  in  NUM_REQ  per-requester command valid
i_req_op  in  NUM_REQ  per-requester op, 1=OP_WRITE, 0=OP_READ
i_req_row  in  NUM_REQ*ROW_BITS  flattened row addresses, requester 0 in LSBs
i_req_col  in  NUM_REQ*COL_BITS  flattened column addresses
i_req_wdata  in  NUM_REQ*DATA_BITS  flattened write data
o_req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
o_cmd_valid  out  1  command to backend valid
o_cmd_op  out  1  head op
o_cmd_row  out  ROW_BITS  head row
o_cmd_col  out  COL_BITS  head column
o_cmd_wdata  out  DATA_BITS  head write data
o_cmd_auto_pre  out  1  auto-precharge decision
i_cmd_ready  in  1  backend ready (backend controller ready)
i_rd_valid  in  1  backend read data valid
i_rd_data  in  DATA_BITS  backend read data
o_rd_valid  out  NUM_REQ  one-hot read return strobe
o_rd_data  out  DATA_BITS  read data (pass-through)
o_err_unexpected_rd  out  1  sticky error flag

Behaviour:
- Reset (async, active-high): queue and tag FIFO emptied, in-flight reads dropped. RR pointer=0, predictor ctr=2'b01, last_valid=0, err=0.
- Reset outputs: o_cmd_valid=0, o_req_ready=0 (forced while reset is asserted), o_rd_valid=0, o_cmd_auto_pre=1.
- Arbitration: when queue count<DEPTH, o_req_ready is one-hot on the first valid requester at or after the RR pointer. It is combinational and zero if no requester is valid or the queue is full.
- On accept (valid&ready): entry {op,row,col,wdata,id} is written to the tail next cycle, and the pointer becomes winner+1 mod NUM_REQ. No full-queue bypass.
- Issue: o_cmd_valid = (count!=0) && !(head is READ && tag FIFO full). Fields come directly from registered head storage. Pop occurs on o_cmd_valid&i_cmd_ready.
- Push and pop in the same cycle are legal at any count; count is unchanged. Enqueue-to-earliest-issue latency is 1 cycle.
- Auto-precharge when count>=2: o_cmd_auto_pre = (entry[head+1].row != head.row).
- Auto-precharge when count==1: o_cmd_auto_pre = ~ctr[1].
- o_cmd_auto_pre may change while waiting. The value sampled at the handshake cycle is binding.
- Predictor update on each pop: if last_valid, ctr saturates up (max 3) when head.row==last_row, else saturates down (min 0). Then last_row<=head.row and last_valid<=1.
- Read tags: a pop of a READ pushes head.id into the tag FIFO.
- Read return: on i_rd_valid with the tag FIFO non-empty, the tag is popped and o_rd_valid[tag]=1 in the same cycle, with o_rd_data=i_rd_data.
- Tag FIFO push and pop in the same cycle are legal.
- i_rd_valid with the tag FIFO empty: data is dropped and o_err_unexpected_rd is set (sticky until reset).
- Requesters must always accept read data; there is no read backpressure.
- Pointers wrap mod DEPTH. Count width is $clog2(DEPTH)+1.

Decomposition:
- Shared package (frontend command package) holds:
  - sched_entry_t struct
  - op encoding (OP_READ/OP_WRITE)
  - PRED_RESET=2'b01
  - ctr saturation limits
- Sub-module sched_sync_fifo, parameterised width/depth, with push, pop, full, empty, head and second-entry peek output.
- sched_sync_fifo is instantiated twice: the command queue (width = entry) and the tag FIFO (width = $clog2(NUM_REQ)).

Test Plan:
- Reset, then single READ from req0 row=5 col=3 -> o_cmd_valid one cycle after accept, o_cmd_auto_pre=1 (ctr=01). With i_rd_valid two cycles after issue, data=0xA5 -> o_rd_valid=2'b01, o_rd_data=0xA5.
- Both requesters valid continuously, i_cmd_ready=1 -> grants alternate 0,1,0,1. Queue order matches and ids are correct.
- i_cmd_ready=0, enqueue rows 7,7,9 -> head auto_pre=0, then after pop auto_pre=1 (lookahead). Queue fills at DEPTH=4 and o_req_ready=0.
- Four single isolated pops, all row=12 -> ctr 01->10->11. The 4th command shows auto_pre=0. Then row=13 pop -> ctr=10.
- Stall reads with tag FIFO full (4 outstanding, no i_rd_valid) -> head READ has o_cmd_valid=0 and head WRITE still issues. Also i_rd_valid with tag FIFO empty -> err=1 and o_rd_valid=0.
- Assert power_on_rst mid-burst with 3 queued and 2 outstanding reads -> all outputs return to reset values immediately. Later i_rd_valid sets the error flag.

Source files
------------

// File: rtl/row_policy_cmd_scheduler_pkg.sv
// Shared frontend command definitions: queue entry layout, op encoding and
// row-hit predictor constants.
package row_policy_cmd_scheduler_pkg;

  localparam int ROW_W  = 14;
  localparam int COL_W  = 10;
  localparam int DATA_W = 64;
  // Wide enough for up to 16 requesters; the tag FIFO keeps only the low bits.
  localparam int ID_W   = 4;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam logic [1:0] PRED_RESET = 2'b01;
  localparam logic [1:0] CTR_MAX    = 2'b11;
  localparam logic [1:0] CTR_MIN    = 2'b00;

  typedef struct packed {
    op_e               op;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] wdata;
    logic [ID_W-1:0]   id;
  } sched_entry_t;

endpackage

// File: rtl/row_policy_cmd_scheduler_fifo.sv
// Synchronous FIFO with head and second-entry peek; used for both the
// command queue and the read-tag FIFO.
module sched_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head,
  output logic [WIDTH-1:0]       second
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q, rd_nxt;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: nothing reads it while count says empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  assign rd_nxt = rd_q + AW'(1);
  assign head   = mem_q[rd_q];
  assign second = mem_q[rd_nxt];
  assign count  = cnt_q;
  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);

endmodule

// File: rtl/row_policy_cmd_scheduler.sv
// Round-robin frontend arbiter feeding an in-order command queue, with
// auto-precharge selection and in-order read-data routing by tag.
module row_policy_cmd_scheduler
  import row_policy_cmd_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DEPTH     = 4,
  parameter int ROW_BITS  = ROW_W,
  parameter int COL_BITS  = COL_W,
  parameter int DATA_BITS = DATA_W
) (
  input  logic                         clk,
  input  logic                         power_on_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ-1:0]           i_req_op,
  input  logic [NUM_REQ*ROW_BITS-1:0]  i_req_row,
  input  logic [NUM_REQ*COL_BITS-1:0]  i_req_col,
  input  logic [NUM_REQ*DATA_BITS-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_cmd_valid,
  output logic                         o_cmd_op,
  output logic [ROW_BITS-1:0]          o_cmd_row,
  output logic [COL_BITS-1:0]          o_cmd_col,
  output logic [DATA_BITS-1:0]         o_cmd_wdata,
  output logic                         o_cmd_auto_pre,
  input  logic                         i_cmd_ready,
  input  logic                         i_rd_valid,
  input  logic [DATA_BITS-1:0]         i_rd_data,
  output logic [NUM_REQ-1:0]           o_rd_valid,
  output logic [DATA_BITS-1:0]         o_rd_data,
  output logic                         o_err_unexpected_rd
);

  localparam int RRW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(DEPTH) + 1;

  logic [RRW-1:0]      rr_q, rr_d, win, idx;
  logic                found, accept, cmd_pop;
  logic [1:0]          ctr_q, ctr_d;
  logic [ROW_BITS-1:0] last_row_q;
  logic                last_valid_q, err_q;

  sched_entry_t        push_entry, cmd_head, cmd_second;
  logic                cmd_full, cmd_empty;
  logic [CW-1:0]       cmd_count;

  logic                tag_push, tag_pop, tag_full, tag_empty;
  logic [RRW-1:0]      tag_head, tag_second;
  logic [CW-1:0]       tag_count;
  logic                unused_bits;

  always_comb begin
    win   = rr_q;
    idx   = rr_q;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = rr_q + RRW'(i);
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign o_req_ready = (found && !cmd_full && !power_on_rst) ? (NUM_REQ'(1) << win) : '0;
  assign accept      = |o_req_ready;
  assign rr_d        = accept ? (win + RRW'(1)) : rr_q;

  always_comb begin
    push_entry       = '0;
    push_entry.op    = op_e'(i_req_op[win]);
    push_entry.row   = i_req_row[win*ROW_BITS +: ROW_BITS];
    push_entry.col   = i_req_col[win*COL_BITS +: COL_BITS];
    push_entry.wdata = i_req_wdata[win*DATA_BITS +: DATA_BITS];
    push_entry.id    = ID_W'(win);
  end

  sched_sync_fifo #(.WIDTH($bits(sched_entry_t)), .DEPTH(DEPTH)) u_cmd_q (
    .clk(clk), .rst(power_on_rst), .push(accept), .pop(cmd_pop), .wdata(push_entry),
    .full(cmd_full), .empty(cmd_empty), .count(cmd_count), .head(cmd_head), .second(cmd_second)
  );

  // A READ may only leave once its tag has somewhere to go.
  assign o_cmd_valid    = !cmd_empty && !(cmd_head.op == OP_READ && tag_full);
  assign cmd_pop        = o_cmd_valid && i_cmd_ready;
  assign o_cmd_op       = cmd_head.op;
  assign o_cmd_row      = cmd_head.row;
  assign o_cmd_col      = cmd_head.col;
  assign o_cmd_wdata    = cmd_head.wdata;
  assign o_cmd_auto_pre = (cmd_count >= CW'(2)) ? (cmd_second.row != cmd_head.row) : ~ctr_q[1];

  always_comb begin
    ctr_d = ctr_q;
    if (cmd_pop && last_valid_q) begin
      if (cmd_head.row == last_row_q) begin
        if (ctr_q != CTR_MAX) ctr_d = ctr_q + 2'd1;
      end else if (ctr_q != CTR_MIN) begin
        ctr_d = ctr_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      rr_q         <= '0;
      ctr_q        <= PRED_RESET;
      last_row_q   <= '0;
      last_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      ctr_q <= ctr_d;
      if (cmd_pop) begin
        last_row_q   <= cmd_head.row;
        last_valid_q <= 1'b1;
      end
      if (i_rd_valid && tag_empty) err_q <= 1'b1;
    end
  end

  assign tag_push = cmd_pop && (cmd_head.op == OP_READ);
  assign tag_pop  = i_rd_valid && !tag_empty;

  sched_sync_fifo #(.WIDTH(RRW), .DEPTH(DEPTH)) u_tag_q (
    .clk(clk), .rst(power_on_rst), .push(tag_push), .pop(tag_pop), .wdata(cmd_head.id[RRW-1:0]),
    .full(tag_full), .empty(tag_empty), .count(tag_count), .head(tag_head), .second(tag_second)
  );

  assign o_rd_valid          = tag_pop ? (NUM_REQ'(1) << tag_head) : '0;
  assign o_rd_data           = i_rd_data;
  assign o_err_unexpected_rd = err_q;

  assign unused_bits = ^{cmd_second.op, cmd_second.col, cmd_second.wdata, cmd_second.id,
                         cmd_head.id, tag_second, tag_count};

endmodule

// File: tb/tb_row_policy_cmd_scheduler.sv
// Directed and randomized stimulus checked each cycle against a queue-based
// model of the scheduler.
module tb_row_policy_cmd_scheduler;

  localparam int N = 2, D = 4, RB = 14, CB = 10, DB = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_valid, req_op, req_ready, o_rd_valid;
  logic [N*RB-1:0] req_row;
  logic [N*CB-1:0] req_col;
  logic [N*DB-1:0] req_wdata;
  logic            cmd_valid, cmd_op, cmd_auto_pre, cmd_ready, rd_valid, err;
  logic [RB-1:0]   cmd_row;
  logic [CB-1:0]   cmd_col;
  logic [DB-1:0]   cmd_wdata, rd_data, o_rd_data;

  always #5 clk = ~clk;

  row_policy_cmd_scheduler #(.NUM_REQ(N), .DEPTH(D), .ROW_BITS(RB), .COL_BITS(CB), .DATA_BITS(DB)) dut (
    .clk(clk), .power_on_rst(rst),
    .i_req_valid(req_valid), .i_req_op(req_op), .i_req_row(req_row), .i_req_col(req_col),
    .i_req_wdata(req_wdata), .o_req_ready(req_ready),
    .o_cmd_valid(cmd_valid), .o_cmd_op(cmd_op), .o_cmd_row(cmd_row), .o_cmd_col(cmd_col),
    .o_cmd_wdata(cmd_wdata), .o_cmd_auto_pre(cmd_auto_pre), .i_cmd_ready(cmd_ready),
    .i_rd_valid(rd_valid), .i_rd_data(rd_data), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_err_unexpected_rd(err)
  );

  typedef struct {
    bit            op;
    logic [RB-1:0] row;
    logic [CB-1:0] col;
    logic [DB-1:0] wdata;
    int            id;
  } ent_t;

  ent_t          q[$];
  int            tags[$];
  int            ctr, rr;
  logic [RB-1:0] last_row;
  bit            last_valid, err_m;
  int            total = 0, bad = 0;

  function automatic void model_reset();
    q.delete();
    tags.delete();
    ctr = 1; rr = 0; last_row = '0; last_valid = 0; err_m = 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input bit v, input bit op, input int row, input int col);
    req_valid[r] = v;
    req_op[r] = op;
    req_row[r*RB +: RB] = RB'(row);
    req_col[r*CB +: CB] = CB'(col);
    req_wdata[r*DB +: DB] = {$urandom, $urandom};
  endtask

  task automatic clr_req();
    req_valid = '0;
  endtask

  // Called at a falling edge with inputs set; checks, advances the model and
  // returns at the next falling edge.
  task automatic tick();
    int w, exp_rv;
    bit exp_cv;
    ent_t e;
    #1;
    w = -1;
    if (q.size() < D)
      for (int i = 0; i < N; i++) begin
        int k;
        k = (rr + i) % N;
        if (w < 0 && req_valid[k]) w = k;
      end
    chk("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
    exp_cv = (q.size() != 0) && !(q[0].op == 0 && tags.size() == D);
    chk("cmd_valid", cmd_valid, exp_cv);
    if (exp_cv) begin
      chk("cmd_op", cmd_op, q[0].op);
      chk("cmd_row", cmd_row, q[0].row);
      chk("cmd_col", cmd_col, q[0].col);
      chk("cmd_wdata", cmd_wdata, q[0].wdata);
      chk("auto_pre", cmd_auto_pre, (q.size() >= 2) ? (q[1].row != q[0].row) : (ctr < 2));
    end
    exp_rv = (rd_valid && tags.size() > 0) ? (1 << tags[0]) : 0;
    chk("rd_valid", o_rd_valid, exp_rv);
    if (exp_rv != 0) chk("rd_data", o_rd_data, rd_data);
    chk("err", err, err_m);

    if (rd_valid) begin
      if (tags.size() > 0) void'(tags.pop_front());
      else err_m = 1;
    end
    if (exp_cv && cmd_ready) begin
      e = q.pop_front();
      if (last_valid) ctr = (e.row == last_row) ? ((ctr < 3) ? ctr + 1 : 3) : ((ctr > 0) ? ctr - 1 : 0);
      last_row = e.row;
      last_valid = 1;
      if (e.op == 0) tags.push_back(e.id);
    end
    if (w >= 0) begin
      e.op = req_op[w];
      e.row = req_row[w*RB +: RB];
      e.col = req_col[w*CB +: CB];
      e.wdata = req_wdata[w*DB +: DB];
      e.id = w;
      q.push_back(e);
      rr = (w + 1) % N;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_rd_valid"}, o_rd_valid, 0);
    chk({tag, "_auto_pre"}, cmd_auto_pre, 1);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    req_valid = '0; req_op = '0; req_row = '0; req_col = '0; req_wdata = '0;
    cmd_ready = 0; rd_valid = 0; rd_data = '0;
    model_reset();

    // Reset state, with requests and read data present during reset
    req_valid = 2'b11;
    rd_valid = 1;
    #12;
    check_reset_outputs("rst");
    req_valid = '0;
    rd_valid = 0;
    @(negedge clk);
    rst = 1'b0;

    // Single READ, issue, then return two cycles later
    set_req(0, 1, 0, 5, 3);
    tick();
    clr_req();
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    tick();
    rd_valid = 1;
    rd_data = 64'hA5;
    tick();
    rd_valid = 0;

    // Both requesters valid continuously: grants must alternate
    cmd_ready = 1;
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1, 1, k, k);
      set_req(1, 1, 1, k + 1, k + 2);
      tick();
    end
    clr_req();
    repeat (3) tick();

    // Lookahead rows 7,7,9 then fill the queue
    cmd_ready = 0;
    set_req(0, 1, 1, 7, 1); tick();
    set_req(0, 1, 1, 7, 2); tick();
    set_req(0, 1, 1, 9, 3); tick();
    set_req(0, 1, 1, 9, 4); tick();
    set_req(1, 1, 1, 9, 5); tick();
    tick();
    clr_req();
    cmd_ready = 1;
    repeat (5) tick();

    // Predictor training on isolated pops from a clean state
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1, 1, (k < 4) ? 12 : 13, k);
      cmd_ready = 0;
      tick();
      clr_req();
      cmd_ready = 1;
      tick();
      cmd_ready = 0;
      tick();
    end

    // Fill the tag FIFO, then a WRITE issues but a READ stalls
    cmd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1, 0, 20, k);
      tick();
    end
    clr_req();
    tick();
    set_req(0, 1, 1, 21, 0); tick();
    set_req(0, 1, 0, 22, 0); tick();
    clr_req();
    repeat (3) tick();
    rd_valid = 1;
    for (int k = 0; k < 8; k++) begin
      rd_data = {$urandom, $urandom};
      tick();
    end
    rd_valid = 0;
    tick();

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      for (int r = 0; r < N; r++)
        set_req(r, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1023));
      cmd_ready = $urandom_range(0, 1);
      rd_valid = ($urandom_range(0, 2) == 0);
      rd_data = {$urandom, $urandom};
      tick();
    end

    // Reset mid-burst: 2 outstanding reads and 3 queued commands
    clr_req();
    cmd_ready = 1;
    rd_valid = 1;
    repeat (10) tick();
    rd_valid = 0;
    set_req(0, 1, 0, 30, 0); tick();
    set_req(0, 1, 0, 31, 0); tick();
    clr_req();
    tick();
    cmd_ready = 0;
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1, 1, 40 + k, k);
      tick();
    end
    req_valid = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clr_req();
    rd_valid = 1;
    rd_data = 64'h1234;
    tick();
    rd_valid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
